// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer slice.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } cd_state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle tick on the last one.
// The divider is frozen while enable is low and returns to zero on clear.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // No divider is needed: every enabled cycle is a tick.
      logic unused_ok;
      assign unused_ok = ^{clk, res, clear};
      assign tick      = enable;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      assign tick = enable && (cnt_q == LAST);

      // Next divider value: clear wins, wrap on tick, advance only while enabled.
      always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (tick)   cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
      end

      // Divider register.
      always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: takes a start value over a valid/ready handshake,
// counts it down to zero at a prescaled rate, then pulses done for one cycle.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (periodic reload from DONE).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  cd_state_e        state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick;

  // The divider only runs in COUNT; any other state holds it at zero, which
  // also gives a fresh divider on every load or reload.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk    (clk),
    .res    (res),
    .clear  (state_q != COUNT),
    .enable (enable && (state_q == COUNT)),
    .tick   (tick)
  );

  // Next state, next count and reload capture.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          out_d    = load_value;
          reload_d = load_value;
          state_d  = (load_value == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // abort beats a simultaneous tick and leaves the count where it is
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          out_d = out_q - 1'b1;
          if (out_q == WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (abort || (reload_q == '0)) begin
          state_d = IDLE;
        end else begin
          state_d = COUNT;
          out_d   = reload_q;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count and reload registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
    end
  end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  // Reload value is only consumed by the periodic mode.
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  assign out        = out_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == COUNT);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer: two instances (PRESCALE 1 and 3) share
// one stimulus stream and are each checked every cycle against a reference model.
module tb_countdown_timer;

  localparam int W  = 4;
  localparam int P0 = 1;
  localparam int P1 = 3;

  logic         clk = 1'b0;
  logic         res, load_valid, enable, abort;
  logic [W-1:0] load_value;
  logic [1:0]        load_ready, busy, done;
  logic [1:0][W-1:0] out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .PRESCALE(P0)) u_dut0 (
    .clk(clk), .res(res), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready[0]), .enable(enable), .abort(abort),
    .out(out[0]), .busy(busy[0]), .done(done[0]));

  countdown_timer #(.WIDTH(W), .PRESCALE(P1)) u_dut1 (
    .clk(clk), .res(res), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready[1]), .enable(enable), .abort(abort),
    .out(out[1]), .busy(busy[1]), .done(done[1]));

  // Reference: "running" means a countdown is in progress, "fin" means this is
  // the completion cycle, "acc" counts enabled cycles since the last decrement.
  typedef struct {
    bit running;
    bit fin;
    int cnt;
    int acc;
    int rld;
  } mdl_t;

  mdl_t m [2];
  bit   saw_busy0, saw_done0;

  function automatic mdl_t mstep(mdl_t s, int p);
    mdl_t n = s;
    if (res) begin
      n.running = 0; n.fin = 0; n.cnt = 0; n.acc = 0; n.rld = 0;
    end else if (s.fin) begin
      n.fin = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      if (!abort && s.rld != 0) begin
        n.running = 1; n.cnt = s.rld; n.acc = 0;
      end
`endif
    end else if (s.running) begin
      if (abort) begin
        n.running = 0;
      end else if (enable) begin
        n.acc = s.acc + 1;
        if (n.acc == p) begin
          n.acc = 0;
          n.cnt = s.cnt - 1;
          if (n.cnt == 0) begin n.running = 0; n.fin = 1; end
        end
      end
    end else if (load_valid) begin
      n.cnt = int'(load_value);
      n.rld = int'(load_value);
      n.acc = 0;
      if (load_value == 0) n.fin = 1;
      else                 n.running = 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance models on the edge, compare outputs on the falling edge.
  task automatic cyc();
    @(posedge clk);
    m[0] = mstep(m[0], P0);
    m[1] = mstep(m[1], P1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out%0d", i),   32'(out[i]),        32'(m[i].cnt));
      chk($sformatf("busy%0d", i),  32'(busy[i]),       32'(m[i].running));
      chk($sformatf("done%0d", i),  32'(done[i]),       32'(m[i].fin));
      chk($sformatf("ready%0d", i), 32'(load_ready[i]), 32'(!m[i].running && !m[i].fin));
    end
    if (busy[0]) saw_busy0 = 1;
    if (done[0]) saw_done0 = 1;
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_value = '0; abort = 0; enable = 1; res = 0;
  endtask

  task automatic load(input int v);
    load_valid = 1; load_value = W'(v);
    cyc();
    load_valid = 0; load_value = '0;
  endtask

  initial begin
    m[0] = '{0, 0, 0, 0, 0};
    m[1] = '{0, 0, 0, 0, 0};
    idle_inputs();
    res = 1;
    cyc(); cyc();
    res = 0;
    cyc();

    // load 5, full countdown on both rates
    load(5);
    repeat (20) cyc();

    // load 0 goes straight to the completion cycle, never counting
    saw_busy0 = 0; saw_done0 = 0;
    load(0);
    repeat (3) cyc();
    chk("zero_busy", 32'(saw_busy0), 32'd0);
    chk("zero_done", 32'(saw_done0), 32'd1);

    // load 2 with an enable gap of 4 cycles mid-count
    load(2);
    repeat (2) cyc();
    enable = 0;
    repeat (4) cyc();
    enable = 1;
    repeat (10) cyc();

    // load 7, ignored reload attempt mid-count, abort once out reaches 4
    saw_done0 = 0;
    load(7);
    load_valid = 1; load_value = W'(9);
    for (int k = 0; k < 40 && m[0].cnt != 4; k++) cyc();
    chk("abort_reach4", 32'(m[0].cnt), 32'd4);
    load_valid = 0;
    abort = 1;
    cyc();
    abort = 0;
    repeat (3) cyc();
    chk("abort_nodone", 32'(saw_done0), 32'd0);

    // reset while counting at 3
    load(9);
    for (int k = 0; k < 40 && m[0].cnt != 3; k++) cyc();
    chk("res_reach3", 32'(m[0].cnt), 32'd3);
    res = 1;
    cyc();
    res = 0;
    repeat (2) cyc();

    // periodic-mode shape (plain mode simply finishes and idles)
    load(3);
    repeat (9) cyc();
    for (int k = 0; k < 10 && !m[0].fin; k++) cyc();
    abort = 1;
    cyc();
    abort = 0;
    repeat (6) cyc();

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_value = W'($urandom);
      enable     = ($urandom_range(0, 4) != 0);
      abort      = ($urandom_range(0, 19) == 0);
      res        = ($urandom_range(0, 79) == 0);
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the counterpart to the team's free-running up-counter.
- Accepts a start value over a valid/ready load handshake, decrements it to zero at a prescaled rate, then pulses done.
- Used as a delay/timeout generator next to the up-counter blocks, in the same single-clock domain.

Parameters:
- WIDTH, 4, bit width of count and load value.
- PRESCALE, 1, clock cycles per decrement (>=1); 1 means decrement every enabled cycle.

Ports:
- clk  input  1  clock; all logic on posedge.
- res  input  1  synchronous, active-high reset.
- load_valid  input  1  start value offered.
- load_value  input  WIDTH  start value.
- load_ready  output  1  timer can accept a load.
- enable  input  1  count qualifier; 0 freezes counter and prescaler.
- abort  input  1  cancel an active count.
- out  output  WIDTH  current count (registered).
- busy  output  1  high in COUNT.
- done  output  1  one-cycle completion pulse (registered).

Behaviour:
- Reset values (res=1 at posedge, highest priority over all inputs): state IDLE, out=0, busy=0, done=0, load_ready=1, prescaler=0, reload register=0.
- States: IDLE, COUNT, DONE. Decoding:
  - load_ready=1 only in IDLE.
  - busy=1 only in COUNT.
  - done=1 only in DONE.
- IDLE: on load_valid && load_ready, out<=load_value, reload<=load_value, prescaler<=0.
  - load_value!=0 -> COUNT.
  - load_value==0 -> DONE.
- COUNT:
  - tick = enable && (prescaler==PRESCALE-1). The prescaler increments only while enable=1 and wraps to 0 on tick.
  - On tick, out<=out-1. If out==1 at the tick, out becomes 0 and state goes to DONE.
  - enable=0 holds out and prescaler.
- abort in COUNT: go to IDLE next edge; out holds its current value; no done pulse. abort has priority over a simultaneous tick. abort is ignored in IDLE.
- DONE: lasts exactly one cycle, then IDLE. out stays 0.
- Latency (PRESCALE=1, enable=1): load accepted at edge k -> out=N after edge k -> out=0 and done=1 after edge k+N -> load_ready=1 after edge k+N+1.
  - Each decrement takes PRESCALE enabled cycles.
- No wrap-around: out never decrements below 0.
- load_valid outside IDLE is ignored; the source must hold it until ready.
- res mid-count returns to reset values at once; no done pulse.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - DONE goes to COUNT with out<=reload and prescaler<=0, giving a periodic done every N+1 cycles (PRESCALE=1).
  - If reload==0, DONE goes to IDLE.
  - abort asserted in DONE also returns to IDLE; done still pulses that cycle.
  - load_ready stays 0 until aborted.
- Undefined: DONE always goes to IDLE. abort in DONE is ignored.

Decomposition:
- Package countdown_pkg:
  - state enum typedef {IDLE, COUNT, DONE}.
  - Default WIDTH constant.
- Sub-module tick_prescaler (params PRESCALE; ports clk, res, clear, enable, tick) generates tick.
  - PRESCALE=1 reduces it to tick=enable.

Test Plan:
- Reset then load 5, enable=1, PRESCALE=1 -> out 5,4,3,2,1,0 on successive cycles; done=1 for exactly one cycle with out=0; load_ready back to 1 the next cycle.
- Load 0 -> DONE the next cycle, done pulse, out=0, no COUNT cycle (busy never 1).
- PRESCALE=3, load 2 -> out=2 for 3 cycles, 1 for 3 cycles, then 0 with done; enable low for 4 cycles mid-count stretches that phase by exactly 4 cycles.
- Load 7, abort after out=4 -> IDLE, out holds 4, done never asserted, load_ready=1; a new load_valid during COUNT is ignored.
- res asserted while out=3 -> next cycle out=0, busy=0, done=0, load_ready=1.
- With COUNTDOWN_AUTO_RELOAD_EN, load 3 -> out sequence 3,2,1,0,3,2,1,0; done every 4th cycle; abort while in DONE -> IDLE after that pulse.
